serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/serial_subtractor_cell.sv | 15 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and one-bit full-subtractor equations for the bit-serial subtractor.
// The cell and any reference model build on these two functions.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic diff_bit(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  // Borrow out when a < b + br, one bit at a time.
  function automatic logic borrow_next(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor, including the FSM state as a debug view.
// Handshake: start is sampled only while idle; done is a one-cycle result-valid pulse, d/bout hold until the next result.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int n = 8
);

  logic         start;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [n-1:0] d;
  logic         bout;
  state_e       state;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, state
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, state
  );

endinterface

// File: rtl/serial_subtractor_cell.sv
// Combinational one-bit full subtractor: diff = x - y - bi, bo = borrow out.
module full_subtractor_cell
  import serial_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = diff_bit(x, y, bi);
  assign bo   = borrow_next(x, y, bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial n-bit subtractor d = a - b - bin, LSB first, with a single borrow flip-flop.
// Operands are captured on start; the result register only changes on the last SHIFT edge.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int n = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(n + 1);

  state_e        r_state;
  logic [n-1:0]  r_sa;
  logic [n-1:0]  r_sb;
  logic [n-1:0]  r_sd;
  logic [n-1:0]  r_d;
  logic          r_br;
  logic          r_bout;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_cnt;

  logic          w_x;
  logic          w_bo;
  logic          w_last;
  logic [n-1:0]  w_sd_next;

  full_subtractor_cell u_cell (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bi   (r_br),
    .diff (w_x),
    .bo   (w_bo)
  );

  // A one-bit result register has no upper bits to shift down.
  generate
    if (n == 1) begin : g_one
      assign w_sd_next = w_x;
    end else begin : g_wide
      assign w_sd_next = {w_x, r_sd[n-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(n - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sd    <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= bus.bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_br  <= w_bo;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sd  <= w_sd_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_d     <= w_sd_next;
            r_bout  <= w_bo;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.d     = r_d;
  assign bus.bout  = r_bout;
  assign bus.state = r_state;

  a_busy_done_exclusive : assert property (@(posedge clk) !(r_busy && r_done));

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: n=8 and n=1 instances against an arithmetic reference model.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.n(8)) bus8 ();
  serial_subtractor_if #(.n(1)) bus1 ();

  serial_subtractor #(.n(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_subtractor #(.n(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last8 = '0;
  logic [31:0] last1 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Result packed as {bout, d}: d = (a - b - bin) mod 2^w, bout = a < b + bin.
  function automatic logic [31:0] ref_sub(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic bin);
    longint diff;
    longint mask;
    logic   bo;
    diff = longint'(a) - longint'(b) - longint'(bin);
    mask = (longint'(1) << w) - 1;
    bo   = longint'(a) < (longint'(b) + longint'(bin));
    return 32'((longint'(bo) << w) | (diff & mask));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
    logic [31:0] exp;
    logic [31:0] got;
    exp = ref_sub(8, 32'(a), 32'(b), bin);
    exp_q.push_back(exp);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.bin = ~bin;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("%s busy k=%0d", tag, k), 32'(bus8.busy), 32'd1);
      check($sformatf("%s done k=%0d", tag, k), 32'(bus8.done), 32'd0);
      check($sformatf("%s d held k=%0d", tag, k), 32'(bus8.d), 32'(last8[7:0]));
      @(negedge clk);
    end
    check({tag, " busy end"}, 32'(bus8.busy), 32'd0);
    check({tag, " done"}, 32'(bus8.done), 32'd1);
    got = {23'd0, bus8.bout, bus8.d};
    check({tag, " result"}, got, exp_q.pop_front());
    last8 = exp;
    @(negedge clk);
    check({tag, " done drop"}, 32'(bus8.done), 32'd0);
    check({tag, " idle"}, 32'(bus8.state), 32'(IDLE));
  endtask

  task automatic run1(input logic a, input logic b, input logic bin, input string tag);
    logic [31:0] exp;
    exp = ref_sub(1, 32'(a), 32'(b), bin);
    exp_q.push_back(exp);
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.bin = bin;
    @(negedge clk);
    bus1.start = 1'b0; bus1.a = ~a; bus1.b = ~b; bus1.bin = ~bin;
    check({tag, " busy"}, 32'(bus1.busy), 32'd1);
    check({tag, " done early"}, 32'(bus1.done), 32'd0);
    check({tag, " d held"}, 32'(bus1.d), 32'(last1[0]));
    @(negedge clk);
    check({tag, " busy end"}, 32'(bus1.busy), 32'd0);
    check({tag, " done"}, 32'(bus1.done), 32'd1);
    check({tag, " result"}, {30'd0, bus1.bout, bus1.d}, exp_q.pop_front());
    last1 = exp;
    @(negedge clk);
    check({tag, " done drop"}, 32'(bus1.done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.bin = 1'b1;
    bus1.start = 1'b1; bus1.a = 1'b1;  bus1.b = 1'b0;  bus1.bin = 1'b0;
    repeat (3) @(negedge clk);
    // start is held high through reset: reset must win.
    check("rst state8", 32'(bus8.state), 32'(IDLE));
    check("rst busy8",  32'(bus8.busy),  32'd0);
    check("rst done8",  32'(bus8.done),  32'd0);
    check("rst d8",     32'(bus8.d),     32'd0);
    check("rst bout8",  32'(bus8.bout),  32'd0);
    check("rst state1", 32'(bus1.state), 32'(IDLE));
    check("rst busy1",  32'(bus1.busy),  32'd0);
    check("rst d1",     32'(bus1.d),     32'd0);
    check("rst bout1",  32'(bus1.bout),  32'd0);
    bus8.start = 1'b0;
    bus1.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // directed n=8 cases
    run8(8'h5A, 8'h3C, 1'b0, "5A-3C");
    run8(8'h00, 8'h01, 1'b0, "00-01");
    run8(8'hFF, 8'hFF, 1'b1, "FF-FF-1");
    run8(8'h03, 8'h01, 1'b0, "03-01 perturbed");

    // start held high: done every 10 cycles, busy for 8 of them
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      check($sformatf("held busy k=%0d", k), 32'(bus8.busy),
            32'(((k % 10) >= 1) && ((k % 10) <= 8)));
      check($sformatf("held done k=%0d", k), 32'(bus8.done), 32'((k % 10) == 9));
      check($sformatf("held d k=%0d", k), 32'(bus8.d), (k < 9) ? 32'(last8[7:0]) : 32'h0F);
      if (k == 29) bus8.start = 1'b0;
    end
    check("held bout", 32'(bus8.bout), 32'd0);
    last8 = ref_sub(8, 32'h10, 32'h01, 1'b0);
    @(negedge clk);
    check("held idle", 32'(bus8.state), 32'(IDLE));
    check("held done drop", 32'(bus8.done), 32'd0);

    // randomized n=8 operations
    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // reset in the fourth SHIFT cycle aborts the operation
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h37; bus8.b = 8'h12; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort state", 32'(bus8.state), 32'(IDLE));
    check("abort busy",  32'(bus8.busy),  32'd0);
    check("abort done",  32'(bus8.done),  32'd0);
    check("abort d",     32'(bus8.d),     32'd0);
    check("abort bout",  32'(bus8.bout),  32'd0);
    rst = 1'b1;
    last8 = '0;
    last1 = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("abort no done k=%0d", k), 32'(bus8.done), 32'd0);
    end
    run8(8'h81, 8'h7F, 1'b0, "post-abort");

    // n=1 instance: directed case first, then every input combination
    run1(1'b0, 1'b1, 1'b0, "n1 0-1");
    for (int v = 0; v < 8; v++) begin
      run1(v[2], v[1], v[0], $sformatf("n1 v%0d", v));
    end

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the stimulus sequence stalls unexpectedly.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
